// File: rtl/sccb_init_sequencer_pkg.sv
// Shared types and constants for the SCCB camera init sequencer: FSM state
// encoding, ROM table markers and a saturating error-count helper.
package sccb_init_sequencer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    XFER,
    RELEASE,
    VFY_XFER,
    VFY_RELEASE,
    DELAY,
    HOST_XFER,
    HOST_RELEASE
  } state_e;

  localparam logic [15:0] END_MARKER     = 16'hFFFF;
  localparam logic [7:0]  DELAY_TAG      = 8'hFE;
  localparam logic [7:0]  DEFAULT_DEV_ID = 8'h42;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sccb_init_sequencer_if.sv
// Control/data bundle between the init sequencer (master) and the SCCB
// master core (slave): start/RW handshake, addresses and data bytes.
interface sccb_init_sequencer_if;

  logic       start;
  logic       rw;
  logic [7:0] ip_addr;
  logic [7:0] sub_addr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       done;

  modport master (
    output start, rw, ip_addr, sub_addr, data_in,
    input  data_out, done
  );

  modport slave (
    input  start, rw, ip_addr, sub_addr, data_in,
    output data_out, done
  );

endinterface

// File: rtl/sccb_init_sequencer_tick_counter.sv
// Loadable down-counter shared by the delay timer and the handshake timeout;
// holds at zero and flags it.
module sccb_init_sequencer_tick_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          zero_o
);

  logic [CW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sccb_init_sequencer.sv
// Walks a camera register-init ROM table through the SCCB master core, with
// embedded delays, optional read-back verify and idle-time host accesses.
module sccb_init_sequencer
  import sccb_init_sequencer_pkg::*;
#(
  parameter int unsigned AW        = 6,
  parameter logic [7:0]  DEV_ID    = DEFAULT_DEV_ID,
  parameter int unsigned MS_CYCLES = 24000,
  parameter int unsigned TIMEOUT   = 32'd1 << 20
) (
  input  logic          xclk_i,
  input  logic          rst_i,
  input  logic          init_go_i,
  input  logic          verify_en_i,
  output logic [AW-1:0] rom_addr_o,
  input  logic [15:0]   rom_data_i,
  input  logic          host_req_i,
  input  logic          host_rw_i,
  input  logic [7:0]    host_sub_addr_i,
  input  logic [7:0]    host_wdata_i,
  output logic          host_ack_o,
  output logic [7:0]    host_rdata_o,
  sccb_init_sequencer_if.master sccb,
  output logic          busy_o,
  output logic          init_done_o,
  output logic          err_o,
  output logic [7:0]    err_count_o
);

  localparam int unsigned DLY_MAX = 255 * MS_CYCLES;
  localparam int unsigned CNT_MAX = (DLY_MAX > TIMEOUT) ? DLY_MAX : TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TIMEOUT_TICKS = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  state_e        adv_state;
  logic          timeout;
  logic          tick_load;
  logic [CW-1:0] tick_val;
  logic [CW-1:0] delay_ticks;
  logic          tick_zero;

  logic [AW-1:0] idx_q;
  logic [7:0]    sub_q, data_q, host_rdata_q, err_count_q;
  logic          rw_q, verify_q, host_ack_q, init_done_q, err_q;
  logic          walk_state;

  sccb_init_sequencer_tick_counter #(.CW(CW)) u_tick (
    .clk_i      (xclk_i),
    .rst_i      (rst_i),
    .load_i     (tick_load),
    .load_val_i (tick_val),
    .en_i       (1'b1),
    .zero_o     (tick_zero)
  );

  // Wrapping past the last table index counts as reaching the end marker.
  assign adv_state   = (idx_q == '1) ? IDLE : FETCH;
  assign delay_ticks = CW'(rom_data_i[7:0]) * CW'(MS_CYCLES) - CW'(1);
  assign walk_state  = (state_q != IDLE) && (state_q != HOST_XFER) &&
                       (state_q != HOST_RELEASE);

  always_ff @(posedge xclk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_go_i)                     state_d = FETCH;
        else if (host_req_i && !host_ack_q) state_d = HOST_XFER;
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        if (rom_data_i == END_MARKER)            state_d = IDLE;
        else if (rom_data_i[15:8] == DELAY_TAG)
          state_d = (rom_data_i[7:0] != 8'd0) ? DELAY : adv_state;
        else                                     state_d = XFER;
      end
      XFER: begin
        if (sccb.done)      state_d = RELEASE;
        else if (tick_zero) begin timeout = 1'b1; state_d = adv_state; end
      end
      RELEASE: begin
        if (!sccb.done)     state_d = verify_q ? VFY_XFER : adv_state;
        else if (tick_zero) begin timeout = 1'b1; state_d = adv_state; end
      end
      VFY_XFER: begin
        if (sccb.done)      state_d = VFY_RELEASE;
        else if (tick_zero) begin timeout = 1'b1; state_d = adv_state; end
      end
      VFY_RELEASE: begin
        if (!sccb.done)     state_d = adv_state;
        else if (tick_zero) begin timeout = 1'b1; state_d = adv_state; end
      end
      DELAY: if (tick_zero) state_d = adv_state;
      HOST_XFER: begin
        if (sccb.done)      state_d = HOST_RELEASE;
        else if (tick_zero) begin timeout = 1'b1; state_d = IDLE; end
      end
      HOST_RELEASE: begin
        if (!sccb.done)     state_d = IDLE;
        else if (tick_zero) begin timeout = 1'b1; state_d = IDLE; end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are driven from their source one cycle ahead of sccb.start so
  // the core always sees them settled before the start edge.
  always_comb begin
    sccb.start    = 1'b0;
    sccb.rw       = rw_q;
    sccb.ip_addr  = DEV_ID;
    sccb.sub_addr = sub_q;
    sccb.data_in  = data_q;
    tick_load     = (state_d != state_q);
    tick_val      = '0;
    case (state_d)
      DELAY: tick_val = delay_ticks;
      XFER, RELEASE, VFY_XFER, VFY_RELEASE, HOST_XFER, HOST_RELEASE:
        tick_val = TIMEOUT_TICKS;
      default: tick_val = '0;
    endcase
    case (state_q)
      XFER, VFY_XFER, HOST_XFER: sccb.start = 1'b1;
      IDLE: begin
        if (state_d == HOST_XFER) begin
          sccb.rw       = host_rw_i;
          sccb.sub_addr = host_sub_addr_i;
          sccb.data_in  = host_wdata_i;
        end
      end
      DECODE: begin
        sccb.rw       = 1'b0;
        sccb.sub_addr = rom_data_i[15:8];
        sccb.data_in  = rom_data_i[7:0];
      end
      RELEASE: if (!sccb.done && verify_q) sccb.rw = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge xclk_i) begin
    if (rst_i) begin
      idx_q        <= '0;
      sub_q        <= '0;
      data_q       <= '0;
      rw_q         <= 1'b0;
      verify_q     <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      init_done_q  <= 1'b0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      host_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_go_i) begin
            idx_q       <= '0;
            verify_q    <= verify_en_i;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
          end else if (state_d == HOST_XFER) begin
            rw_q   <= host_rw_i;
            sub_q  <= host_sub_addr_i;
            data_q <= host_wdata_i;
          end
        end
        DECODE: begin
          rw_q   <= 1'b0;
          sub_q  <= rom_data_i[15:8];
          data_q <= rom_data_i[7:0];
        end
        RELEASE: if (!sccb.done && verify_q) rw_q <= 1'b1;
        VFY_XFER: begin
          if (sccb.done && (sccb.data_out != data_q)) begin
            err_q       <= 1'b1;
            err_count_q <= sat_inc(err_count_q);
          end
        end
        HOST_XFER: if (sccb.done && rw_q) host_rdata_q <= sccb.data_out;
        HOST_RELEASE: if (!sccb.done) host_ack_q <= 1'b1;
        default: ;
      endcase
      if (timeout) begin
        err_q       <= 1'b1;
        err_count_q <= sat_inc(err_count_q);
        if (state_q == HOST_XFER || state_q == HOST_RELEASE) begin
          host_ack_q <= 1'b1;
          if (rw_q) host_rdata_q <= 8'h00;
        end
      end
      if (state_d == FETCH && state_q != IDLE) idx_q <= idx_q + 1'b1;
      if (state_d == IDLE && walk_state)      init_done_q <= 1'b1;
    end
  end

  assign rom_addr_o   = idx_q;
  assign host_ack_o   = host_ack_q;
  assign host_rdata_o = host_rdata_q;
  assign busy_o       = (state_q != IDLE);
  assign init_done_o  = init_done_q;
  assign err_o        = err_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Scoreboard bench: directed ROM tables and host accesses against a simple
// SCCB core model; a monitor checks every issued transaction and host reply.
module tb_sccb_init_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned MS = 10;
  localparam int unsigned TO = 64;

  typedef struct packed {
    logic       rw;
    logic [7:0] sub;
    logic [7:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_go = 1'b0, verify_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic          host_req = 1'b0, host_rw = 1'b0;
  logic [7:0]    host_sub = 8'h00, host_wdata = 8'h00;
  logic          host_ack, busy, init_done, err;
  logic [7:0]    host_rdata, err_count;

  sccb_init_sequencer_if sif ();

  sccb_init_sequencer #(.AW(AW), .DEV_ID(8'h42), .MS_CYCLES(MS), .TIMEOUT(TO)) dut (
    .xclk_i          (clk),
    .rst_i           (rst),
    .init_go_i       (init_go),
    .verify_en_i     (verify_en),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .host_req_i      (host_req),
    .host_rw_i       (host_rw),
    .host_sub_addr_i (host_sub),
    .host_wdata_i    (host_wdata),
    .host_ack_o      (host_ack),
    .host_rdata_o    (host_rdata),
    .sccb            (sif),
    .busy_o          (busy),
    .init_done_o     (init_done),
    .err_o           (err),
    .err_count_o     (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ROM and core models
  logic [15:0] rom [2**AW];
  logic [7:0]  mem [256];
  logic        stall_once = 1'b0;
  logic        bad11 = 1'b0;
  int          m_cnt = 0;

  initial begin
    sif.done     = 1'b0;
    sif.data_out = 8'h00;
  end

  always @(negedge clk) begin
    rom_data = rom[rom_addr];
    if (rst) begin
      sif.done = 1'b0;
      m_cnt    = 0;
    end else if (!sif.done) begin
      if (sif.start) begin
        m_cnt++;
        if (m_cnt >= 2 && !stall_once) begin
          sif.done = 1'b1;
          m_cnt    = 0;
          if (sif.rw) sif.data_out = (bad11 && sif.sub_addr == 8'h11) ? 8'h00 : mem[sif.sub_addr];
          else        mem[sif.sub_addr] = sif.data_in;
        end
      end else begin
        if (stall_once && m_cnt != 0) stall_once = 1'b0;
        m_cnt = 0;
      end
    end else if (!sif.start) begin
      sif.done = 1'b0;
    end
  end

  // Scoreboard monitor
  txn_t       exp_q[$];
  logic [7:0] exp_host_q[$];
  int         rise_q[$];
  int         hi_len_q[$];
  int         cyc = 0;
  int         hi_run = 0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    txn_t e;
    cyc++;
    if (sif.start && !prev_start) begin
      rise_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_txn", {15'd0, sif.rw, sif.sub_addr, sif.data_in}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("txn", {15'd0, sif.rw, sif.sub_addr, sif.data_in}, {15'd0, e});
      end
    end
    if (sif.start) hi_run++;
    else if (prev_start) begin
      hi_len_q.push_back(hi_run);
      hi_run = 0;
    end
    prev_start = sif.start;
    if (host_ack) begin
      if (exp_host_q.size() == 0) check("unexpected_host_ack", 32'd1, 32'd0);
      else check("host_rdata", {24'd0, host_rdata}, {24'd0, exp_host_q.pop_front()});
    end
  end

  task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    for (int i = 0; i < 2**AW; i++) rom[i] = 16'hFFFF;
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic push_txn(input logic rw, input logic [7:0] sub, input logic [7:0] data);
    txn_t t;
    t.rw = rw; t.sub = sub; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic pulse_init(input logic v);
    @(negedge clk);
    verify_en = v;
    init_go   = 1'b1;
    @(negedge clk);
    init_go   = 1'b0;
  endtask

  task automatic wait_walk(input string name);
    int n = 0;
    while (!(init_done && !busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_walk_finished"}, {31'd0, n < 2000}, 32'd1);
  endtask

  int r0, n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_start", {31'd0, sif.start}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_ip_addr", {24'd0, sif.ip_addr}, 32'h42);
    check("rst_host_ack", {31'd0, host_ack}, 32'd0);

    // Two plain writes, verify off; first start 3 cycles after init_go
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    pulse_init(1'b0);
    n = 1;
    while (!sif.start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_start_latency", n, 32'd3);
    wait_walk("t1");
    check("t1_init_done", {31'd0, init_done}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_drained", exp_q.size(), 32'd0);

    // Baseline with a zero delay entry, then a 2 ms entry: gap grows by 2*MS
    load_rom(16'h1280, 16'hFE00, 16'h1101, 16'hFFFF);
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    rise_q.delete();
    pulse_init(1'b0);
    wait_walk("t2a");
    r0 = (rise_q.size() == 2) ? rise_q[1] - rise_q[0] : -1;
    load_rom(16'h1280, 16'hFE02, 16'h1101, 16'hFFFF);
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    rise_q.delete();
    pulse_init(1'b0);
    wait_walk("t2b");
    check("t2_rise_count", rise_q.size(), 32'd2);
    if (rise_q.size() == 2) check("t2_delay_gap", (rise_q[1] - rise_q[0]) - r0, 2 * MS);
    check("t2_drained", exp_q.size(), 32'd0);

    // Verify on, read-back of 0x11 returns 0x00
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
    bad11 = 1'b1;
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b1, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    push_txn(1'b1, 8'h11, 8'h01);
    pulse_init(1'b1);
    wait_walk("t3");
    bad11 = 1'b0;
    check("t3_err", {31'd0, err}, 32'd1);
    check("t3_err_count", {24'd0, err_count}, 32'd1);
    check("t3_init_done", {31'd0, init_done}, 32'd1);
    check("t3_drained", exp_q.size(), 32'd0);

    // Core never answers the first write: timeout, then next entry
    hi_len_q.delete();
    stall_once = 1'b1;
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    pulse_init(1'b0);
    wait_walk("t4");
    check("t4_hi_runs", hi_len_q.size(), 32'd2);
    if (hi_len_q.size() >= 1) check("t4_timeout_len", hi_len_q[0], TO);
    check("t4_err", {31'd0, err}, 32'd1);
    check("t4_err_count", {24'd0, err_count}, 32'd1);
    check("t4_drained", exp_q.size(), 32'd0);

    // Host read requested mid-walk is served after init_done
    mem[8'h0A] = 8'h76;
    push_txn(1'b0, 8'h12, 8'h80);
    push_txn(1'b0, 8'h11, 8'h01);
    push_txn(1'b1, 8'h0A, 8'h00);
    exp_host_q.push_back(8'h76);
    pulse_init(1'b0);
    host_rw  = 1'b1;
    host_sub = 8'h0A;
    host_req = 1'b1;
    n = 0;
    while (!host_ack && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t5_ack_seen", {31'd0, host_ack}, 32'd1);
    check("t5_init_done_at_ack", {31'd0, init_done}, 32'd1);
    host_req = 1'b0;
    @(negedge clk);
    check("t5_ack_pulse", {31'd0, host_ack}, 32'd0);
    check("t5_drained", exp_q.size() + exp_host_q.size(), 32'd0);

    // Reset in the middle of XFER
    stall_once = 1'b1;
    push_txn(1'b0, 8'h12, 8'h80);
    pulse_init(1'b0);
    n = 0;
    while (!sif.start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_in_xfer", {31'd0, sif.start}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_start", {31'd0, sif.start}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_init_done", {31'd0, init_done}, 32'd0);
    rst = 1'b0;
    stall_once = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle_after", {31'd0, busy}, 32'd0);
    check("t6_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
